prt_dp_pm_loader: RTL and testbench
===================================

Name: prt_dp_pm_loader

Overview:
Upstream loader for the policy-maker program RAM. It receives a program image as a byte stream from the host side (MCU or UART bridge) and validates the header, length and checksum. It assembles little-endian 32-bit words and drives the RAM initialization port (start/data/valid). It holds the policy-maker processor in reset for the duration of a load and releases it only after a good image.

Parameters:
P_ADR, 10, program RAM address bits; maximum image size is 2**P_ADR words
P_MAGIC, 16'h504D, required header magic ("PM")

Ports:
CLK_IN  in  1  clock
RST_IN  in  1  reset, synchronous, active-high
LDR_STR_IN  in  1  start-of-image pulse
LDR_DAT_IN  in  8  image byte
LDR_VLD_IN  in  1  byte valid
LDR_RDY_OUT  out  1  loader accepts bytes
INIT_STR_OUT  out  1  RAM write-pointer clear pulse
INIT_DAT_OUT  out  32  RAM word
INIT_VLD_OUT  out  1  RAM word valid
PM_RST_OUT  out  1  policy-maker processor reset
DONE_OUT  out  1  image loaded and verified, level
ERR_OUT  out  2  0 none, 1 header, 2 length, 3 checksum; level

Behaviour:
- Image format, all fields little-endian: magic (2 B), length N in words (2 B), N×4 data bytes, checksum (4 B). Checksum = sum of the N data words mod 2^32.
- A byte is accepted when LDR_VLD_IN && LDR_RDY_OUT. LDR_RDY_OUT=1 only in HDR, DATA and CHK. There is no backpressure inside these states.
- States:
  - IDLE -> HDR on LDR_STR_IN.
  - HDR: 4 bytes. Check magic and length, then go to DATA, or to ERR if a check fails.
  - DATA: N×4 bytes, then CHK.
  - CHK: 4 bytes, then DONE or ERR.
  - DONE and ERR are held until the next LDR_STR_IN.
- LDR_STR_IN in any state, including mid-load: abort and restart in HDR. It clears the byte counter, word counter and checksum, and sets DONE_OUT=0 and ERR_OUT=0. A byte valid in the same cycle as LDR_STR_IN is discarded.
- LDR_STR_IN also produces INIT_STR_OUT as a 1-cycle pulse, registered (1 cycle after LDR_STR_IN). It sets PM_RST_OUT=1 on the same cycle.
- Header checks are made after the 4th header byte:
  - magic != P_MAGIC -> ERR_OUT=1.
  - N==0 or N>2**P_ADR -> ERR_OUT=2.
  - Magic is evaluated first.
- Word assembly: byte k of a word (k=0..3) goes to bits [8k+7:8k]. When byte 3 is accepted, the next cycle has INIT_VLD_OUT=1 for exactly one cycle, with INIT_DAT_OUT holding the word. The checksum accumulates the same word. Latency is 1 cycle from byte-3 acceptance. INIT_DAT_OUT holds its last value otherwise.
- Counters: a 2-bit byte counter wraps 3->0. The word counter is P_ADR+1 bits, so N=2**P_ADR is representable.
- CHK: after the 4th checksum byte, compare against the accumulated sum.
  - Match: DONE_OUT=1 and PM_RST_OUT=0 on the next cycle.
  - Mismatch: ERR_OUT=3, and PM_RST_OUT stays 1. The RAM contents are invalid and the processor is held.
- Bytes arriving in IDLE, DONE or ERR are ignored (LDR_RDY_OUT=0).
- Reset values: state IDLE; LDR_RDY_OUT=0, INIT_STR_OUT=0, INIT_VLD_OUT=0, INIT_DAT_OUT=0, PM_RST_OUT=0 (the RAM holds its init-file image), DONE_OUT=0, ERR_OUT=0.
- Reset mid-load: return immediately to the reset values. A partial image stays in the RAM; this is accepted because the host must reload.

Decomposition:
- prt_dp_pm_loader_pkg holds:
  - state enum (IDLE, HDR, DATA, CHK, DONE, ERR);
  - error code constants (ERR_NONE, ERR_HDR, ERR_LEN, ERR_CHK);
  - header byte count (4) and checksum byte count (4).
- One natural sub-module, prt_dp_pm_loader_asm: byte-to-word assembler with byte counter, producing a 1-cycle word strobe. The FSM, counters and checksum remain in the top level.

Test Plan:
- Good image: STR, bytes 4D 50 02 00, 78 56 34 12, 01 00 00 00, checksum 79 56 34 12 -> INIT_STR_OUT pulse. INIT_VLD_OUT twice, with 0x12345678 then 0x00000001. DONE_OUT=1, ERR_OUT=0, PM_RST_OUT falls one cycle after the last byte.
- Bad magic 4D 51 02 00 -> ERR_OUT=1 after the 4th byte, no INIT_VLD_OUT, LDR_RDY_OUT=0, PM_RST_OUT=1.
- Length 0x0000 and length 0x0401 (P_ADR=10) -> ERR_OUT=2. Length 0x0400 with 1024 words and a correct checksum -> DONE_OUT=1 with 1024 INIT_VLD_OUT pulses.
- Good image but checksum byte 0 off by one -> ERR_OUT=3, DONE_OUT=0, PM_RST_OUT=1.
- Abort: STR, header plus 6 data bytes, then STR with a valid byte in the same cycle, then a full good image -> second INIT_STR_OUT pulse, the same-cycle byte discarded, only the new image's words written, DONE_OUT=1.
- Gapped LDR_VLD_IN (1 in 3 cycles) plus RST_IN asserted mid-DATA -> words are correct despite gaps. After reset, all outputs are at their reset values and LDR_RDY_OUT=0 until the next STR.

Source files
------------

// File: rtl/prt_dp_pm_loader_pkg.sv
// Shared types and constants for the policy-maker program loader.
package prt_dp_pm_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Error codes reported on ERR_OUT
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_CHK  = 2'd3;

    // Image framing: header and checksum are each exactly one assembled word
    localparam int HDR_BYTES  = 4;
    localparam int CHK_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // Header check on the assembled header word {len[15:0], magic[15:0]}.
    // Magic is judged before length so a garbage stream reports ERR_HDR.
    function automatic logic [1:0] f_hdr_check(
        input logic [31:0] i_hdr,
        input logic [15:0] i_magic,
        input logic [16:0] i_max_words
    );
        logic [16:0] v_len;
        v_len = {1'b0, i_hdr[31:16]};
        if (i_hdr[15:0] != i_magic) begin
            return ERR_HDR;
        end
        if ((v_len == 17'd0) || (v_len > i_max_words)) begin
            return ERR_LEN;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/prt_dp_pm_loader_asm.sv
// Little-endian byte-to-word assembler. Byte k of a word lands in bits
// [8k+7:8k]. The completed word is offered combinationally on the cycle the
// last byte is accepted, and optionally registered with a 1-cycle strobe.
module prt_dp_pm_loader_asm
    import prt_dp_pm_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_acc,
    input  logic [7:0]  i_byte,
    input  logic        i_emit,
    output logic [1:0]  o_bcnt,
    output logic        o_last,
    output logic [31:0] o_word_cmb,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    localparam logic [1:0] LP_LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  r_bcnt;
    logic [23:0] r_part;
    logic [31:0] r_word;
    logic        r_word_vld;
    logic        w_last;

    assign w_last     = i_acc && (r_bcnt == LP_LAST_IDX);
    assign o_word_cmb = {i_byte, r_part};
    assign o_last     = w_last;
    assign o_bcnt     = r_bcnt;
    assign o_word     = r_word;
    assign o_word_vld = r_word_vld;

    // Shift bytes in from the top so earlier bytes end up in lower lanes;
    // the byte counter wraps 3->0 naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcnt     <= 2'd0;
            r_part     <= 24'd0;
            r_word     <= 32'd0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clr) begin
                r_bcnt <= 2'd0;
            end else if (i_acc) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_part <= {i_byte, r_part[23:8]};
                if (w_last && i_emit) begin
                    r_word     <= o_word_cmb;
                    r_word_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prt_dp_pm_loader.sv
// Policy-maker program loader: validates a byte-stream image, writes its
// words to the program RAM init port and holds the processor in reset
// until a complete image has passed its checksum.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset; bytes ignored, processor runs from init image
//   HDR     | collecting magic + length (4 bytes)
//   DATA    | collecting N data words, writing RAM, summing
//   CHK     | collecting checksum (4 bytes)
//   DONE    | image verified, processor released; held until next start
//   ERR     | header/length/checksum failure, processor held in reset
module prt_dp_pm_loader
    import prt_dp_pm_loader_pkg::*;
#(
    parameter int          P_ADR   = 10,
    parameter logic [15:0] P_MAGIC = 16'h504D
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic        LDR_STR_IN,
    input  logic [7:0]  LDR_DAT_IN,
    input  logic        LDR_VLD_IN,
    output logic        LDR_RDY_OUT,
    output logic        INIT_STR_OUT,
    output logic [31:0] INIT_DAT_OUT,
    output logic        INIT_VLD_OUT,
    output logic        PM_RST_OUT,
    output logic        DONE_OUT,
    output logic [1:0]  ERR_OUT
);

    localparam logic [16:0]  LP_MAX_WORDS = 17'(2 ** P_ADR);
    localparam logic [1:0]   LP_HDR_LAST  = 2'(HDR_BYTES - 1);
    localparam logic [1:0]   LP_CHK_LAST  = 2'(CHK_BYTES - 1);
    localparam logic [P_ADR:0] LP_WCNT_ONE = (P_ADR + 1)'(1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_rdy;
    logic           w_acc;
    logic [1:0]     w_bcnt;
    logic           w_word_last;
    logic           w_hdr_last;
    logic           w_chk_last;
    logic [31:0]    w_word_cmb;
    logic [31:0]    w_word;
    logic           w_word_vld;
    logic [1:0]     w_hdr_err;
    logic           w_sum_ok;

    logic [31:0]    r_sum;
    logic [P_ADR:0] r_wcnt;
    logic           r_init_str;
    logic           r_pm_rst;
    logic           r_done;
    logic [1:0]     r_err;

    assign w_rdy = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    // A byte coinciding with a start pulse belongs to the aborted stream
    assign w_acc = LDR_VLD_IN && w_rdy && !LDR_STR_IN;

    prt_dp_pm_loader_asm u_asm (
        .i_clk      (CLK_IN),
        .i_rst      (RST_IN),
        .i_clr      (LDR_STR_IN),
        .i_acc      (w_acc),
        .i_byte     (LDR_DAT_IN),
        .i_emit     (r_state == ST_DATA),
        .o_bcnt     (w_bcnt),
        .o_last     (w_word_last),
        .o_word_cmb (w_word_cmb),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

    assign w_hdr_last = w_acc && (w_bcnt == LP_HDR_LAST);
    assign w_chk_last = w_acc && (w_bcnt == LP_CHK_LAST);
    assign w_hdr_err  = f_hdr_check(w_word_cmb, P_MAGIC, LP_MAX_WORDS);
    assign w_sum_ok   = (w_word_cmb == r_sum);

    // State register
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a start pulse restarts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (LDR_STR_IN) begin
            w_state_nxt = ST_HDR;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_hdr_last) begin
                        w_state_nxt = (w_hdr_err == ERR_NONE) ? ST_DATA : ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (w_word_last && (r_wcnt == LP_WCNT_ONE)) begin
                        w_state_nxt = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (w_chk_last) begin
                        w_state_nxt = w_sum_ok ? ST_DONE : ST_ERR;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Word counter (down-count to the last word), checksum and status levels
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_sum      <= 32'd0;
            r_wcnt     <= '0;
            r_init_str <= 1'b0;
            r_pm_rst   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= ERR_NONE;
        end else begin
            r_init_str <= LDR_STR_IN;
            if (LDR_STR_IN) begin
                r_sum    <= 32'd0;
                r_wcnt   <= '0;
                r_pm_rst <= 1'b1;
                r_done   <= 1'b0;
                r_err    <= ERR_NONE;
            end else begin
                case (r_state)
                    ST_HDR: begin
                        if (w_hdr_last) begin
                            if (w_hdr_err != ERR_NONE) begin
                                r_err <= w_hdr_err;
                            end else begin
                                r_wcnt <= w_word_cmb[16 +: P_ADR + 1];
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_word_last) begin
                            r_sum  <= r_sum + w_word_cmb;
                            r_wcnt <= r_wcnt - LP_WCNT_ONE;
                        end
                    end
                    ST_CHK: begin
                        if (w_chk_last) begin
                            if (w_sum_ok) begin
                                r_done   <= 1'b1;
                                r_pm_rst <= 1'b0;
                            end else begin
                                r_err <= ERR_CHK;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign LDR_RDY_OUT  = w_rdy;
    assign INIT_STR_OUT = r_init_str;
    assign INIT_DAT_OUT = w_word;
    assign INIT_VLD_OUT = w_word_vld;
    assign PM_RST_OUT   = r_pm_rst;
    assign DONE_OUT     = r_done;
    assign ERR_OUT      = r_err;

endmodule

// File: tb/tb_prt_dp_pm_loader.sv
// Bench for the policy-maker program loader: image-level reference model,
// directed scenarios and randomized images with gapped byte streams.
module tb_prt_dp_pm_loader;

    localparam int          P_ADR   = 10;
    localparam logic [15:0] P_MAGIC = 16'h504D;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        str;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        init_str;
    logic [31:0] init_dat;
    logic        init_vld;
    logic        pm_rst;
    logic        done;
    logic [1:0]  err;

    int          n_tot = 0;
    int          n_bad = 0;
    int          str_cnt = 0;
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    prt_dp_pm_loader #(.P_ADR(P_ADR), .P_MAGIC(P_MAGIC)) dut (
        .CLK_IN       (clk),
        .RST_IN       (rst),
        .LDR_STR_IN   (str),
        .LDR_DAT_IN   (dat),
        .LDR_VLD_IN   (vld),
        .LDR_RDY_OUT  (rdy),
        .INIT_STR_OUT (init_str),
        .INIT_DAT_OUT (init_dat),
        .INIT_VLD_OUT (init_vld),
        .PM_RST_OUT   (pm_rst),
        .DONE_OUT     (done),
        .ERR_OUT      (err)
    );

    // RAM-side view: a start pulse clears the write pointer, so the RAM
    // holds exactly the words written since the last start pulse.
    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
        end else begin
            if (init_str) begin
                str_cnt++;
                got_q.delete();
            end
            if (init_vld) got_q.push_back(init_dat);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Image semantics: what the RAM should contain and how the load ends
    function automatic void ref_model(input bq_t img, output logic [1:0] e_err,
                                      output logic e_done, output wq_t e_words);
        logic [15:0] magic;
        logic [15:0] len;
        logic [31:0] sum;
        logic [31:0] w;
        logic [31:0] cs;
        int          base;
        e_words = {};
        e_err   = 2'd0;
        e_done  = 1'b0;
        sum     = 32'd0;
        magic   = {img[1], img[0]};
        len     = {img[3], img[2]};
        if (magic != P_MAGIC) begin
            e_err = 2'd1;
        end else if (len == 16'd0 || int'(len) > (1 << P_ADR)) begin
            e_err = 2'd2;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                base = 4 + 4 * i;
                w = {img[base+3], img[base+2], img[base+1], img[base]};
                e_words.push_back(w);
                sum = sum + w;
            end
            base = 4 + 4 * int'(len);
            cs = {img[base+3], img[base+2], img[base+1], img[base]};
            if (cs == sum) e_done = 1'b1;
            else           e_err  = 2'd3;
        end
    endfunction

    // Header, then data and checksum (checksum + delta) if data is given
    function automatic void build_img(input logic [15:0] magic, input logic [15:0] len,
                                      input wq_t data, input logic [31:0] cs_delta,
                                      output bq_t img);
        logic [31:0] sum;
        img = {};
        sum = 32'd0;
        img.push_back(magic[7:0]);
        img.push_back(magic[15:8]);
        img.push_back(len[7:0]);
        img.push_back(len[15:8]);
        foreach (data[i]) begin
            sum = sum + data[i];
            for (int k = 0; k < 4; k++) img.push_back(data[i][8*k +: 8]);
        end
        if (data.size() > 0) begin
            sum = sum + cs_delta;
            for (int k = 0; k < 4; k++) img.push_back(sum[8*k +: 8]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            vld = 1'b0;
            dat = 8'($urandom);
            tick();
        end
        vld = 1'b1;
        dat = b;
        tick();
        vld = 1'b0;
    endtask

    task automatic pulse_str(input logic with_byte, input string tag);
        str = 1'b1;
        vld = with_byte;
        dat = 8'($urandom);
        tick();
        str = 1'b0;
        vld = 1'b0;
        check_val({tag, ".init_str"}, {31'd0, init_str}, 32'd1);
        check_val({tag, ".pm_rst_load"}, {31'd0, pm_rst}, 32'd1);
        check_val({tag, ".clr_status"}, {29'd0, done, err}, 32'd0);
    endtask

    task automatic run_image(input bq_t img, input int gap_max, input string tag, input logic with_byte);
        logic [1:0] e_err;
        logic       e_done;
        wq_t        e_words;
        int         n;
        ref_model(img, e_err, e_done, e_words);
        pulse_str(with_byte, tag);
        for (int i = 0; i < img.size() - 1; i++) begin
            send_byte(img[i], int'($urandom_range(0, gap_max)));
        end
        check_val({tag, ".rdy_busy"}, {31'd0, rdy}, 32'd1);
        check_val({tag, ".pm_rst_pre"}, {31'd0, pm_rst}, 32'd1);
        check_val({tag, ".done_pre"}, {31'd0, done}, 32'd0);
        send_byte(img[img.size() - 1], int'($urandom_range(0, gap_max)));
        check_val({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
        check_val({tag, ".err"}, {30'd0, err}, {30'd0, e_err});
        check_val({tag, ".pm_rst"}, {31'd0, pm_rst}, {31'd0, !e_done});
        check_val({tag, ".rdy_end"}, {31'd0, rdy}, 32'd0);
        tick();
        check_val({tag, ".nwords"}, got_q.size(), e_words.size());
        for (int i = 0; i < e_words.size() && i < got_q.size(); i++) begin
            check_val($sformatf("%s.w%0d", tag, i), got_q[i], e_words[i]);
        end
        n = got_q.size();
        repeat (3) send_byte(8'($urandom), 0);
        tick();
        check_val({tag, ".ignored"}, got_q.size(), n);
        check_val({tag, ".hold"}, {29'd0, done, err}, {29'd0, e_done, e_err});
    endtask

    initial begin
        bq_t         img;
        wq_t         d;
        int          kind;
        int          nw;
        int          s0;
        logic [15:0] m;
        logic [15:0] l;
        logic [31:0] delta;

        rst = 1'b1;
        str = 1'b0;
        vld = 1'b0;
        dat = 8'd0;
        repeat (3) tick();
        check_val("rst.outs", {rdy, init_str, init_vld, pm_rst, done, err}, 32'd0);
        check_val("rst.dat", init_dat, 32'd0);
        rst = 1'b0;
        send_byte(8'h4D, 0);
        tick();
        check_val("idle.ignore", {rdy, init_vld, pm_rst, done, err}, 32'd0);

        // Reference image
        d = {32'h12345678, 32'h00000001};
        build_img(P_MAGIC, 16'd2, d, 32'd0, img);
        check_val("good.cs_byte0", {24'd0, img[12]}, 32'h79);
        run_image(img, 0, "good", 1'b0);
        check_val("good.w0_const", got_q.size() > 0 ? got_q[0] : 32'hDEAD_BEEF, 32'h12345678);

        // Header failures
        d = {};
        build_img(16'h514D, 16'd2, d, 32'd0, img);
        run_image(img, 1, "magic", 1'b0);
        build_img(P_MAGIC, 16'h0000, d, 32'd0, img);
        run_image(img, 1, "len0", 1'b0);
        build_img(P_MAGIC, 16'h0401, d, 32'd0, img);
        run_image(img, 1, "len401", 1'b0);

        // Checksum off by one
        d = {32'h12345678, 32'h00000001};
        build_img(P_MAGIC, 16'd2, d, 32'd1, img);
        run_image(img, 0, "cs_bad", 1'b0);

        // Maximum image size
        d = {};
        for (int i = 0; i < (1 << P_ADR); i++) d.push_back($urandom);
        build_img(P_MAGIC, 16'h0400, d, 32'd0, img);
        run_image(img, 0, "max", 1'b0);

        // Abort mid-data, restart with a same-cycle byte that must be dropped
        s0 = str_cnt;
        d = {32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        build_img(P_MAGIC, 16'd3, d, 32'd0, img);
        pulse_str(1'b0, "abort_a");
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        tick();
        check_val("abort.partial", got_q.size(), 1);
        d = {32'h0BAD_F00D, 32'h1111_2222};
        build_img(P_MAGIC, 16'd2, d, 32'd0, img);
        run_image(img, 1, "abort_b", 1'b1);
        check_val("abort.str_cnt", str_cnt, s0 + 2);

        // Gapped stream (1 byte in 3 cycles), reset in the middle of DATA
        d = {};
        for (int i = 0; i < 6; i++) d.push_back($urandom);
        build_img(P_MAGIC, 16'd6, d, 32'd0, img);
        pulse_str(1'b0, "gap");
        for (int i = 0; i < 14; i++) send_byte(img[i], 2);
        tick();
        check_val("gap.nwords", got_q.size(), 2);
        check_val("gap.w0", got_q.size() > 0 ? got_q[0] : 32'hDEAD_BEEF, d[0]);
        check_val("gap.w1", got_q.size() > 1 ? got_q[1] : 32'hDEAD_BEEF, d[1]);
        rst = 1'b1;
        tick();
        check_val("midrst.outs", {rdy, init_str, init_vld, pm_rst, done, err}, 32'd0);
        check_val("midrst.dat", init_dat, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(img[i], 0);
        tick();
        check_val("midrst.idle", {rdy, init_vld, pm_rst, done, err}, 32'd0);
        check_val("midrst.nowords", got_q.size(), 0);
        run_image(img, 2, "post_rst", 1'b0);

        // Randomized images
        for (int it = 0; it < 24; it++) begin
            kind  = int'($urandom_range(0, 3));
            nw    = int'($urandom_range(1, 8));
            m     = P_MAGIC;
            l     = 16'(nw);
            delta = 32'd0;
            d     = {};
            for (int j = 0; j < nw; j++) d.push_back($urandom);
            case (kind)
                1: begin
                    m = P_MAGIC ^ (16'd1 << $urandom_range(0, 15));
                    d = {};
                end
                2: begin
                    l = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1025, 65535));
                    d = {};
                end
                3: delta = 32'($urandom_range(1, 255));
                default: ;
            endcase
            build_img(m, l, d, delta, img);
            run_image(img, 2, $sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
